// File: rtl/pc_fetch_gen.sv
// Fetch-address generator: presents the fetch PC over a valid/ready handshake, buffers one
// redirect under backpressure, and (with PC_BTB_EN defined) predicts taken branches via a BTB.
module pc_fetch_gen #(
    parameter logic [31:0] RESET_ADDR = 32'hbfc0_0000,
    parameter logic [31:0] EXC_ADDR   = 32'hbfc0_0380,
    parameter int          BTB_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        exc_oc,
    input  logic        br_redirect,
    input  logic [31:0] br_target,
    input  logic        bu_valid,
    input  logic [31:0] bu_pc,
    input  logic        bu_taken,
    input  logic [31:0] bu_target,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_pc,
    output logic        fetch_stale,
    output logic        fetch_pred_taken,
    output logic [31:0] fetch_pred_target
);

    // Handshake: a request fires when fetch_valid && fetch_ready; fetch_pc is held
    // stable while fetch_valid=1 and fetch_ready=0.

    logic        valid_q;
    logic [31:0] pc_q, pc_d;
    logic        pend_v_q, pend_v_d;
    logic [31:0] pend_pc_q, pend_pc_d;

    logic        fire;
    logic        redir;
    logic [31:0] rt;
    logic        pred_taken;
    logic [31:0] pred_target;

    assign fire  = valid_q & fetch_ready;
    assign redir = eret | exc_oc | br_redirect;

    always_comb begin
        rt = 32'h0;
        if (eret) begin
            rt = epc;
        end else if (exc_oc) begin
            rt = EXC_ADDR;
        end else if (br_redirect) begin
            rt = br_target;
        end
    end

`ifdef PC_BTB_EN
    localparam int IW = $clog2(BTB_DEPTH);

    logic [BTB_DEPTH-1:0] btb_v_q;
    logic [29-IW:0]       btb_tag_q [BTB_DEPTH];
    logic [31:0]          btb_tgt_q [BTB_DEPTH];

    logic [IW-1:0]  lk_idx;
    logic [29-IW:0] lk_tag;
    logic [31:0]    up_pc;
    logic [IW-1:0]  up_idx;
    logic [29-IW:0] up_tag;
    logic           unused_up_low;

    assign lk_idx = pc_q[IW+1:2];
    assign lk_tag = pc_q[31:IW+2];

    // Entries are keyed by the delay-slot PC so the target follows the delay slot.
    assign up_pc         = bu_pc + 32'd4;
    assign up_idx        = up_pc[IW+1:2];
    assign up_tag        = up_pc[31:IW+2];
    assign unused_up_low = ^up_pc[1:0];

    assign pred_taken  = btb_v_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
    assign pred_target = pred_taken ? btb_tgt_q[lk_idx] : 32'h0;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            btb_v_q <= '0;
        end else if (bu_valid) begin
            if (bu_taken) begin
                btb_v_q[up_idx] <= 1'b1;
            end else if (btb_tag_q[up_idx] == up_tag) begin
                btb_v_q[up_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (resetn && bu_valid && bu_taken) begin
            btb_tag_q[up_idx] <= up_tag;
            btb_tgt_q[up_idx] <= bu_target;
        end
    end
`else
    logic unused_bu;

    assign unused_bu   = ^{bu_valid, bu_pc, bu_taken, bu_target};
    assign pred_taken  = 1'b0;
    assign pred_target = 32'h0;
`endif

    always_comb begin
        pc_d      = pc_q;
        pend_v_d  = pend_v_q;
        pend_pc_d = pend_pc_q;
        if (fire) begin
            pend_v_d = 1'b0;
            if (redir) begin
                pc_d = rt;
            end else if (pend_v_q) begin
                pc_d = pend_pc_q;
            end else if (pred_taken) begin
                pc_d = pred_target;
            end else begin
                pc_d = pc_q + 32'd4;
            end
        end else if (redir) begin
            // Youngest redirect wins while stalled.
            pend_v_d  = 1'b1;
            pend_pc_d = rt;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q   <= 1'b0;
            pc_q      <= RESET_ADDR;
            pend_v_q  <= 1'b0;
            pend_pc_q <= 32'h0;
        end else begin
            valid_q   <= 1'b1;
            pc_q      <= pc_d;
            pend_v_q  <= pend_v_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign fetch_valid       = valid_q;
    assign fetch_pc          = pc_q;
    assign fetch_stale       = pend_v_q;
    assign fetch_pred_taken  = pred_taken;
    assign fetch_pred_target = pred_target;

endmodule

// File: doc/pc_fetch_gen.md
# pc_fetch_gen

Parametrised fetch-address generator for the MIPS core front end. It is the next generation of the single-register PC. It presents the fetch PC to the instruction-fetch bridge through a valid/ready handshake. It holds the address stable under backpressure and buffers one redirect that arrives while a request is stalled. It optionally predicts taken branches with a direct-mapped BTB indexed by delay-slot PC.

## Interface
Parameters:
- RESET_ADDR, 32'hbfc0_0000: PC after reset.
- EXC_ADDR, 32'hbfc0_0380: exception entry vector.
- BTB_DEPTH, 16: BTB entries; power of 2, 2..256.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- eret  in  1  ERET redirect; target is epc.
- epc  in  32  ERET target.
- exc_oc  in  1  exception redirect; target is EXC_ADDR.
- br_redirect  in  1  branch/mispredict redirect; target is br_target.
- br_target  in  32  branch redirect target.
- bu_valid  in  1  BTB update strobe.
- bu_pc  in  32  PC of the resolved branch.
- bu_taken  in  1  resolved direction.
- bu_target  in  32  resolved taken target.
- fetch_valid  out  1  fetch request valid.
- fetch_ready  in  1  bridge accepts the request.
- fetch_pc  out  32  fetch address.
- fetch_stale  out  1  the presented request precedes a buffered redirect; the pipeline discards it.
- fetch_pred_taken  out  1  BTB hit on fetch_pc.
- fetch_pred_target  out  32  predicted target; 0 when no hit.

## Operation
- Handshake: a fire occurs when fetch_valid and fetch_ready are both high. fetch_valid is 1 in every cycle after reset. fetch_pc must not change while fetch_valid=1 and fetch_ready=0.
- Redirect priority within one cycle: eret > exc_oc > br_redirect. The selected target is the redirect target (rt).
- Pending slot: pend_v and pend_pc, one entry.
- Next-PC selection on a fire, in priority order: rt if any redirect is present this cycle; else pend_pc if pend_v=1; else fetch_pred_target on a BTB hit; else fetch_pc+4. pend_v is cleared on every fire.
- With no fire and a redirect present: pend_pc <= rt and pend_v <= 1. A later redirect overwrites an earlier pending one (youngest wins).
- fetch_stale = pend_v. It is registered, with no combinational path from the redirect inputs. A request fired in the same cycle as a redirect is the pipeline's responsibility to flush.
- Low two bits of redirect targets pass through unmodified. Address errors are checked downstream.
- BTB, when compiled in:
  - Each entry holds valid, tag and target.
  - Index = pc[IW+1:2], where IW = log2(BTB_DEPTH). Tag = pc[31:IW+2].
  - Lookup is combinational on fetch_pc.
  - Entries are keyed by the delay-slot PC, bu_pc+4, so the target is fetched after the delay slot.
  - Update on bu_valid with bu_taken=1: write valid=1, tag and bu_target at index(bu_pc+4).
  - Update on bu_valid with bu_taken=0: clear valid at that index only if the stored tag matches.
  - A lookup in the same cycle as an update sees the old contents.

## Timing
- Reset values:
  - fetch_valid=0.
  - fetch_pc=RESET_ADDR.
  - fetch_stale=0.
  - pend_v=0.
  - All BTB valid bits = 0, cleared in one cycle.
  - fetch_pred_taken=0.
  - fetch_pred_target=0.
- fetch_valid rises in the first cycle with resetn=1.
- Redirect at cycle t with fire at t: fetch_pc=rt at t+1.
- Redirect at t without fire: fetch_pc holds, fetch_stale=1 from t+1, and fetch_pc=rt the cycle after the next fire.
- Fire with pending and a new redirect in the same cycle: the new rt is used and the pending entry is dropped.
- BTB update at t is visible to lookup at t+1.
- resetn low in any state, including with pend_v=1 or fetch_ready=0, returns all state to the reset values in the next cycle.
- Sequential arithmetic is 32-bit modulo: 32'hffff_fffc+4 wraps to 0.

## Configuration
- PC_BTB_EN defined: BTB storage and prediction as above.
- PC_BTB_EN undefined:
  - No BTB storage.
  - fetch_pred_taken=0 and fetch_pred_target=0 constant.
  - bu_* inputs are ignored.
  - Next PC on a fire is rt, else pend_pc, else fetch_pc+4.

## Test plan
- Reset, then fetch_ready=1 held: fetch_pc sequence is bfc0_0000, bfc0_0004, bfc0_0008; fetch_valid=0 only during reset.
- fetch_ready=0 for 3 cycles, br_redirect with target 8000_1000 in the 2nd cycle: fetch_pc holds; fetch_stale=1 from the 3rd cycle; after fetch_ready=1 and a fire, fetch_pc=8000_1000 and fetch_stale=0.
- Simultaneous eret (epc=8000_0200), exc_oc and br_redirect with a fire: next fetch_pc=8000_0200. The same inputs without eret give bfc0_0380.
- Two redirects while stalled (8000_0100, then 8000_0200): after the fire, fetch_pc=8000_0200.
- PC_BTB_EN: update with bu_pc=8000_0010, taken, target 8000_0400. Fetching 8000_0014 then gives pred_taken=1 and next fetch_pc=8000_0400. A not-taken update then clears the entry; an aliasing PC with a different tag neither hits nor clears it.
- resetn asserted with pend_v=1 and a BTB entry valid: after reset, fetch_pc=bfc0_0000, fetch_stale=0, and no BTB hit.
